branch_tag_allocator: RTL and testbench

Allocates branch checkpoint tags to the dispatch group leaving the instruction buffer, one tag per branch, up to four per cycle. It sits directly downstream of the instruction buffer, beside rename. It consumes the buffer's ready signal, branch count and per-slot branch flags. It drives a branch-resource stall back into the front end and a registered tag bundle forward to rename. Tags are returned on branch resolution and all are reclaimed on flush.

---
 rtl/branch_tag_if.sv | 38 +++
 rtl/branch_tag_allocator.sv | 102 ++++++++++
 tb/tb_branch_tag_allocator.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/branch_tag_if.sv
// Dispatch-group handshake between instruction buffer, rename and the
// branch tag allocator: group request, resolve return and tag bundle.
interface branch_tag_if #(
  parameter int TAG_LOG      = 3,
  parameter int BRANCH_COUNT = 3
) ();
  logic                    flush_i;
  logic                    stall_i;
  logic                    instBufferReady_i;
  logic [BRANCH_COUNT-1:0] branchCount_i;
  logic [3:0]              branchVector_i;
  logic                    resolveValid_i;
  logic [TAG_LOG-1:0]      resolveTag_i;
  logic                    branchStall_o;
  logic                    groupValid_o;
  logic [3:0]              tagValid_o;
  logic [TAG_LOG-1:0]      tag0_o;
  logic [TAG_LOG-1:0]      tag1_o;
  logic [TAG_LOG-1:0]      tag2_o;
  logic [TAG_LOG-1:0]      tag3_o;
  logic [TAG_LOG:0]        freeCount_o;

  modport master (
    output flush_i, stall_i, instBufferReady_i,
    output branchCount_i, branchVector_i,
    output resolveValid_i, resolveTag_i,
    input  branchStall_o, groupValid_o, tagValid_o,
    input  tag0_o, tag1_o, tag2_o, tag3_o, freeCount_o
  );

  modport slave (
    input  flush_i, stall_i, instBufferReady_i,
    input  branchCount_i, branchVector_i,
    input  resolveValid_i, resolveTag_i,
    output branchStall_o, groupValid_o, tagValid_o,
    output tag0_o, tag1_o, tag2_o, tag3_o, freeCount_o
  );
endinterface

// File: rtl/branch_tag_allocator.sv
// Branch checkpoint tag allocator: hands out up to four lowest-index free
// tags per dispatch group, reclaims on resolve, resets all on flush.
module branch_tag_allocator #(
  parameter int DISPATCH_WIDTH = 4,
  parameter int NUM_TAGS       = 8,
  parameter int TAG_LOG        = 3,
  parameter int BRANCH_COUNT   = 3
) (
  input logic        clk,
  input logic        reset_n,
  branch_tag_if.slave bt
);
  localparam int CW = TAG_LOG + 1;

  logic [NUM_TAGS-1:0]           free_q, free_d;
  logic [CW-1:0]                 cnt_q, cnt_d;
  logic                          gv_q, gv_d;
  logic [3:0]                    tv_q, tv_d;
  logic [3:0][TAG_LOG-1:0]       tag_q, tag_d;

  logic [NUM_TAGS-1:0]           avail;
  logic [NUM_TAGS-1:0]           rel_mask;
  logic [3:0][TAG_LOG-1:0]       tag_a;
  logic [CW-1:0]                 nalloc;
  logic                          found;
  logic                          rel;
  logic                          stall;
  logic                          accept;

  assign stall  = bt.instBufferReady_i
                & (CW'(bt.branchCount_i) > cnt_q);
  assign accept = bt.instBufferReady_i & ~bt.stall_i
                & ~stall & ~bt.flush_i;

  // Each branch slot takes the lowest tag still free after earlier slots.
  always_comb begin
    avail  = free_q;
    tag_a  = '0;
    nalloc = '0;
    found  = 1'b0;
    for (int s = 0; s < DISPATCH_WIDTH; s++) begin
      found = 1'b0;
      for (int t = 0; t < NUM_TAGS; t++) begin
        if (bt.branchVector_i[s] && !found && avail[t]) begin
          tag_a[s] = TAG_LOG'(t);
          avail[t] = 1'b0;
          found    = 1'b1;
        end
      end
      if (found) nalloc = nalloc + CW'(1);
    end
  end

  assign rel      = bt.resolveValid_i & ~free_q[bt.resolveTag_i];
  assign rel_mask = rel ? (NUM_TAGS'(1) << bt.resolveTag_i)
                        : '0;

  always_comb begin
    free_d = free_q;
    cnt_d  = cnt_q;
    gv_d   = 1'b0;
    tv_d   = '0;
    tag_d  = '0;
    if (bt.flush_i) begin
      free_d = '1;
      cnt_d  = CW'(NUM_TAGS);
    end else begin
      free_d = (accept ? avail : free_q) | rel_mask;
      cnt_d  = cnt_q - (accept ? nalloc : '0) + CW'(rel);
      gv_d   = accept;
      if (accept) begin
        tv_d  = bt.branchVector_i;
        tag_d = tag_a;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      free_q <= '1;
      cnt_q  <= CW'(NUM_TAGS);
      gv_q   <= 1'b0;
      tv_q   <= '0;
      tag_q  <= '0;
    end else begin
      free_q <= free_d;
      cnt_q  <= cnt_d;
      gv_q   <= gv_d;
      tv_q   <= tv_d;
      tag_q  <= tag_d;
    end
  end

  assign bt.branchStall_o = stall;
  assign bt.groupValid_o  = gv_q;
  assign bt.tagValid_o    = tv_q;
  assign bt.tag0_o        = tag_q[0];
  assign bt.tag1_o        = tag_q[1];
  assign bt.tag2_o        = tag_q[2];
  assign bt.tag3_o        = tag_q[3];
  assign bt.freeCount_o   = cnt_q;
endmodule

// File: tb/tb_branch_tag_allocator.sv
// Bench for branch_tag_allocator: directed vector table, async reset
// corner, then random traffic against a free-list queue model.
module tb_branch_tag_allocator;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

  branch_tag_if #(.TAG_LOG(3), .BRANCH_COUNT(3)) bt ();

  branch_tag_allocator #(
    .DISPATCH_WIDTH(4), .NUM_TAGS(8),
    .TAG_LOG(3), .BRANCH_COUNT(3)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bt(bt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       fl;
    bit       st;
    bit       rdy;
    int       cnt;
    bit [3:0] vec;
    bit       rv;
    int       rt;
    bit       e_stall;
    bit       e_gv;
    bit [3:0] e_tv;
    int       e_t0, e_t1, e_t2, e_t3;
    int       e_fc;
  } vec_t;

  vec_t tbl[$];

  int       mfree[$];
  bit       m_gv;
  bit [3:0] m_tv;
  int       m_tag[4];

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    mfree.delete();
    for (int i = 0; i < 8; i++) mfree.push_back(i);
    m_gv = 0;
    m_tv = 0;
    for (int i = 0; i < 4; i++) m_tag[i] = 0;
  endfunction

  function automatic bit model_stall(bit rdy, int cnt);
    return rdy && (cnt > mfree.size());
  endfunction

  function automatic void model_step(bit fl, bit st, bit rdy, int cnt,
                                     bit [3:0] vec, bit rv, int rt);
    bit acc;
    bit was_free;
    for (int i = 0; i < 4; i++) m_tag[i] = 0;
    if (fl) begin
      model_reset();
      return;
    end
    acc = rdy && !st && !model_stall(rdy, cnt);
    was_free = 0;
    foreach (mfree[i]) if (mfree[i] == rt) was_free = 1;
    m_gv = acc;
    m_tv = acc ? vec : 4'b0;
    if (acc)
      for (int s = 0; s < 4; s++)
        if (vec[s]) m_tag[s] = mfree.pop_front();
    if (rv && !was_free) begin
      mfree.push_back(rt);
      mfree.sort();
    end
  endfunction

  task automatic drive(bit fl, bit st, bit rdy, int cnt,
                       bit [3:0] vec, bit rv, int rt);
    bt.flush_i           = fl;
    bt.stall_i           = st;
    bt.instBufferReady_i = rdy;
    bt.branchCount_i     = 3'(cnt);
    bt.branchVector_i    = vec;
    bt.resolveValid_i    = rv;
    bt.resolveTag_i      = 3'(rt);
  endtask

  task automatic check_regs(string p, bit gv, bit [3:0] tv,
                            int t0, int t1, int t2, int t3, int fc);
    chk({p, "_gv"}, int'(bt.groupValid_o), int'(gv));
    chk({p, "_tv"}, int'(bt.tagValid_o), int'(tv));
    chk({p, "_t0"}, int'(bt.tag0_o), t0);
    chk({p, "_t1"}, int'(bt.tag1_o), t1);
    chk({p, "_t2"}, int'(bt.tag2_o), t2);
    chk({p, "_t3"}, int'(bt.tag3_o), t3);
    chk({p, "_fc"}, int'(bt.freeCount_o), fc);
  endtask

  function automatic vec_t mk(bit fl, bit st, bit rdy, int cnt,
      bit [3:0] vec, bit rv, int rt, bit es, bit egv, bit [3:0] etv,
      int t0, int t1, int t2, int t3, int fc);
    vec_t v;
    v.fl = fl; v.st = st; v.rdy = rdy; v.cnt = cnt; v.vec = vec;
    v.rv = rv; v.rt = rt; v.e_stall = es; v.e_gv = egv; v.e_tv = etv;
    v.e_t0 = t0; v.e_t1 = t1; v.e_t2 = t2; v.e_t3 = t3; v.e_fc = fc;
    return v;
  endfunction

  initial begin
    //            fl st rdy cnt vec     rv rt  stl gv tv      t0 t1 t2 t3 fc
    tbl.push_back(mk(0, 0, 1, 3, 4'b1011, 0, 0, 0, 1, 4'b1011, 0, 1, 0, 2, 5));
    tbl.push_back(mk(0, 0, 1, 3, 4'b0111, 0, 0, 0, 1, 4'b0111, 3, 4, 5, 0, 2));
    tbl.push_back(mk(0, 0, 1, 3, 4'b1110, 0, 0, 1, 0, 4'b0000, 0, 0, 0, 0, 2));
    tbl.push_back(mk(0, 0, 1, 3, 4'b1110, 1, 1, 1, 0, 4'b0000, 0, 0, 0, 0, 3));
    tbl.push_back(mk(0, 0, 1, 3, 4'b1110, 0, 0, 0, 1, 4'b1110, 0, 1, 6, 7, 0));
    tbl.push_back(mk(0, 0, 1, 1, 4'b0100, 1, 4, 1, 0, 4'b0000, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 1, 4'b0100, 0, 0, 0, 1, 4'b0100, 0, 0, 4, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 4'b0000, 1, 2, 0, 0, 4'b0000, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 1, 4'b0001, 1, 2, 0, 1, 4'b0001, 2, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 4'b0000, 1, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0, 4'b0000, 1, 3, 0, 1, 4'b0000, 0, 0, 0, 0, 2));
    tbl.push_back(mk(0, 1, 1, 2, 4'b0011, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 2));
    tbl.push_back(mk(1, 0, 1, 2, 4'b0011, 1, 5, 0, 0, 4'b0000, 0, 0, 0, 0, 8));
    tbl.push_back(mk(0, 0, 1, 4, 4'b1111, 0, 0, 0, 1, 4'b1111, 0, 1, 2, 3, 4));

    drive(0, 0, 0, 0, 4'b0, 0, 0);
    #1 reset_n = 1'b0;
    #2;
    chk("rst_stall", int'(bt.branchStall_o), 0);
    check_regs("rst", 0, 4'b0, 0, 0, 0, 0, 8);
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
    model_reset();

    foreach (tbl[i]) begin
      vec_t v;
      string nm;
      v = tbl[i];
      nm = $sformatf("vec%0d", i);
      drive(v.fl, v.st, v.rdy, v.cnt, v.vec, v.rv, v.rt);
      @(negedge clk);
      chk({nm, "_stall"}, int'(bt.branchStall_o), int'(v.e_stall));
      model_step(v.fl, v.st, v.rdy, v.cnt, v.vec, v.rv, v.rt);
      @(posedge clk);
      #1;
      check_regs(nm, v.e_gv, v.e_tv, v.e_t0, v.e_t1, v.e_t2, v.e_t3,
                 v.e_fc);
    end

    drive(0, 0, 0, 0, 4'b0, 0, 0);
    #1 reset_n = 1'b0;
    #1;
    chk("async_stall", int'(bt.branchStall_o), 0);
    check_regs("async", 0, 4'b0, 0, 0, 0, 0, 8);
    @(posedge clk);
    #1 reset_n = 1'b1;
    model_reset();

    for (int n = 0; n < 3000; n++) begin
      bit       fl, st, rdy, rv;
      bit [3:0] vec;
      int       cnt, rt;
      fl  = ($urandom_range(99) < 3);
      st  = ($urandom_range(99) < 20);
      rdy = ($urandom_range(99) < 80);
      vec = 4'($urandom);
      cnt = $countones(vec);
      rv  = ($urandom_range(99) < 55);
      rt  = $urandom_range(7);
      drive(fl, st, rdy, cnt, vec, rv, rt);
      @(negedge clk);
      chk("rnd_stall", int'(bt.branchStall_o),
          int'(model_stall(rdy, cnt)));
      chk("rnd_fc_pre", int'(bt.freeCount_o), mfree.size());
      model_step(fl, st, rdy, cnt, vec, rv, rt);
      @(posedge clk);
      #1;
      check_regs("rnd", m_gv, m_tv, m_tag[0], m_tag[1], m_tag[2],
                 m_tag[3], mfree.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
